neuron_lane_array: RTL
======================

Name: neuron_lane_array

Overview:
- Parametrised successor to the single hidden-unit MAC block.
- NUM_UNITS lanes share one input stream. Each lane owns a weight RAM and a signed fixed-point MAC.
- A sequencer FSM runs a dot product of configurable length over all lanes in parallel. Results are saturated back to DATA_WIDTH and delivered through a valid/ready handshake.
- Sits between the layer input buffer and the activation/output buffer of a fully-connected layer.

Parameters:
- DATA_WIDTH, 16, signed fixed-point word width (input, weight, result).
- FRAC_BITS, 8, fractional bits of the Q format.
- NUM_UNITS, 4, number of parallel lanes (hidden units).
- BRAM_DEPTH, 256, weights per lane; maximum dot-product length.
- ACC_WIDTH, 2*DATA_WIDTH+8, signed accumulator width.
- W_ADDR_BITS, $clog2(BRAM_DEPTH), weight address width.
- U_SEL_BITS, max(1,$clog2(NUM_UNITS)), lane-select width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  weight write strobe.
- wr_unit  in  U_SEL_BITS  target lane for the write.
- wr_addr  in  W_ADDR_BITS  weight index.
- wr_data  in  DATA_WIDTH  weight value.
- start  in  1  begin a dot product (single-cycle pulse).
- length  in  W_ADDR_BITS+1  number of inputs; sampled on start.
- busy  out  1  high from the accepted start until the output handshake completes.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input activation x.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- out_data  out  NUM_UNITS*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- overflow  out  NUM_UNITS  per-lane saturation flag; qualified by out_valid.

Behaviour:
- Reset: FSM returns to IDLE; busy, in_ready, out_valid, out_data and overflow all go to 0; accumulators and counters are cleared. RAM contents are not reset. Reset mid-operation aborts the run with no output.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - wr_en writes wr_data to lane wr_unit at wr_addr.
  - A wr_unit value >= NUM_UNITS is ignored.
  - start with length 0 goes directly to DONE with all results 0.
  - start with length >= 1 goes to RUN. length is clamped to BRAM_DEPTH, the index counter is cleared, and accumulators are cleared.
- RUN:
  - in_ready = 1.
  - Each accepted x reads weight[idx] from every lane; idx is then incremented.
  - RAM read latency is 1 cycle; x is delayed 1 cycle to align with the weight.
  - The product is accumulated on the following edge.
  - Gaps in in_valid stall the pipeline with no accumulation.
  - When the last input is accepted, go to DRAIN.
- DRAIN:
  - Lasts exactly 2 cycles, then goes to DONE.
  - out_valid rises 3 cycles after the last input handshake.
- DONE:
  - out_valid = 1.
  - Each lane output is sat(acc >>> FRAC_BITS): arithmetic shift, truncation toward -inf, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - overflow[k] = 1 if clamping occurred on lane k.
  - out_data and overflow stay stable while out_ready = 0.
  - When out_valid && out_ready, go to IDLE. out_valid drops the next cycle; out_data holds its last value.
- busy = 1 in RUN, DRAIN and DONE.
- start and wr_en are ignored while busy. A dropped write has no side effect.
- Accumulator arithmetic: full-precision product, sign-extended to ACC_WIDTH; accumulator wraps modulo 2^ACC_WIDTH. With the default ACC_WIDTH, wrap cannot occur for BRAM_DEPTH=256.

Optional Feature:
- Macro: NEURON_RELU_EN.
- Defined: each lane result passes through ReLU after saturation. Negative values output 0; overflow still reflects saturation only.
- Undefined: results are the signed saturated values.

Decomposition:
- Package nn_pkg holds:
  - the state typedef (IDLE/RUN/DRAIN/DONE);
  - a sat_shift function (shift, clamp, overflow flag);
  - the default width localparams.
- Sub-module neuron_lane: weight RAM, aligned MAC, accumulator and saturation for one lane. It is instantiated NUM_UNITS times by a generate loop.
- The top level holds the FSM, index counter, input alignment register and handshake logic.

Test Plan:
- Basic dot product:
  - Setup: lane0 weights {256, 512, -256}; lane1 weights {128, 128, 128}; start with length=3.
  - Stimulus: x = {256, 256, 256} with in_valid held continuously.
  - Required: out_valid rises 3 cycles after the 3rd accept; lane0 = 512; lane1 = 384; overflow = 0.
- Saturation:
  - Stimulus: all weights 0x7FFF, length=4, x = 0x7FFF each.
  - Required: lane0 = 0x7FFF, overflow[0] = 1. The negative case (weights 0x8000) gives 0x8000 (or 0 under NEURON_RELU_EN).
- Output backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles in DONE, pulsing start and wr_en during that time.
  - Required: out_data stable, busy = 1, start ignored, RAM unchanged (verified by a rerun).
- Input bubbles:
  - Stimulus: in_valid pattern 1,0,0,1,0,1 with length=3.
  - Required: same results as the basic dot product; in_ready = 0 outside RUN.
- Reset mid-RUN:
  - Stimulus: assert rst after 2 of 3 inputs.
  - Required: out_valid, busy, out_data = 0 immediately (asynchronous). A subsequent run reproduces the basic dot-product results, confirming the weights were retained.
- Edge lengths:
  - length=0: out_valid one cycle after start, all zeros.
  - length=BRAM_DEPTH+1: clamped; exactly BRAM_DEPTH inputs accepted.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared state type, default widths and the fixed-point shift/saturate helper
// used by the neuron lane array.
package nn_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_FRAC_BITS  = 8;
   localparam int unsigned DEF_NUM_UNITS  = 4;
   localparam int unsigned DEF_BRAM_DEPTH = 256;

   // Working width of sat_shift; accumulators must not be wider than this.
   localparam int unsigned SAT_MAX_W = 128;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   typedef struct packed {
      logic [SAT_MAX_W-1:0] val;
      logic                 ovf;
   } sat_t;

   // acc arrives sign-extended to SAT_MAX_W; the caller keeps the low dw bits of val.
   function automatic sat_t sat_shift(input logic signed [SAT_MAX_W-1:0] acc,
                                      input int unsigned frac, input int unsigned dw);
      logic signed [SAT_MAX_W-1:0] sh;
      logic signed [SAT_MAX_W-1:0] max_v;
      logic signed [SAT_MAX_W-1:0] min_v;
      logic signed [SAT_MAX_W-1:0] one;
      sat_t r;
      one   = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
      sh    = acc >>> frac;
      max_v = (one <<< (dw - 1)) - one;
      min_v = -max_v - one;
      r.ovf = 1'b1;
      if (sh > max_v) begin
         r.val = max_v;
      end else if (sh < min_v) begin
         r.val = min_v;
      end else begin
         r.val = sh;
         r.ovf = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/neuron_lane.sv
// One hidden unit: weight RAM, input-aligned MAC, accumulator and saturated result register.
// Optional NEURON_RELU_EN zeroes negative results after saturation.
module neuron_lane
   import nn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS   = DEF_FRAC_BITS,
   parameter int unsigned BRAM_DEPTH  = DEF_BRAM_DEPTH,
   parameter int unsigned ACC_WIDTH   = 2 * DEF_DATA_WIDTH + 8,
   parameter int unsigned W_ADDR_BITS = $clog2(DEF_BRAM_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [W_ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   input  logic [W_ADDR_BITS-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]  x,
   input  logic                   acc_en,
   input  logic                   clr,
   input  logic                   load,
   input  logic                   load_zero,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   ovf
);

   logic [DATA_WIDTH-1:0]          mem [BRAM_DEPTH];
   logic [DATA_WIDTH-1:0]          w_q;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0]          res_d;
   logic [DATA_WIDTH-1:0]          result_q;
   logic                           ovf_q;
   sat_t                           sat;
   logic                           unused_sat_hi;

   // Weight RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q <= '0;
      end else if (rd_en) begin
         w_q <= mem[rd_addr];
      end
   end

   assign prod = (2*DATA_WIDTH)'($signed(x)) * (2*DATA_WIDTH)'($signed(w_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (acc_en) begin
         acc_q <= acc_q + ACC_WIDTH'(prod);
      end
   end

   always_comb begin
      sat   = sat_shift(SAT_MAX_W'(acc_q), FRAC_BITS, DATA_WIDTH);
      res_d = sat.val[DATA_WIDTH-1:0];
`ifdef NEURON_RELU_EN
      if (res_d[DATA_WIDTH-1]) begin
         res_d = '0;
      end
`endif
   end

   assign unused_sat_hi = ^sat.val[SAT_MAX_W-1:DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (load) begin
         result_q <= load_zero ? '0 : res_d;
         ovf_q    <= load_zero ? 1'b0 : sat.ovf;
      end
   end

   assign result = result_q;
   assign ovf    = ovf_q;

endmodule

// File: rtl/neuron_lane_array.sv
// NUM_UNITS parallel fixed-point MAC lanes sharing one input stream, with sequencer FSM
// and valid/ready result delivery. Optional NEURON_RELU_EN applies ReLU to lane results.
module neuron_lane_array
   import nn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS   = DEF_FRAC_BITS,
   parameter int unsigned NUM_UNITS   = DEF_NUM_UNITS,
   parameter int unsigned BRAM_DEPTH  = DEF_BRAM_DEPTH,
   parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH + 8,
   parameter int unsigned W_ADDR_BITS = $clog2(BRAM_DEPTH),
   parameter int unsigned U_SEL_BITS  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic [U_SEL_BITS-1:0]           wr_unit,
   input  logic [W_ADDR_BITS-1:0]          wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            start,
   input  logic [W_ADDR_BITS:0]            length,
   output logic                            busy,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_UNITS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_UNITS-1:0]            overflow
);

   localparam logic [W_ADDR_BITS:0] DepthLen = (W_ADDR_BITS+1)'(BRAM_DEPTH);
   localparam logic [W_ADDR_BITS:0] IdxOne   = {{W_ADDR_BITS{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [W_ADDR_BITS:0]  len_q, len_d;
   logic [W_ADDR_BITS:0]  idx_q, idx_d;
   logic                  drain_q, drain_d;
   logic [DATA_WIDTH-1:0] x_q;
   logic                  v_q;
   logic                  accept, last;
   logic                  clr, load, load_zero;
   logic [W_ADDR_BITS:0]  len_clamped;

   assign len_clamped = (length > DepthLen) ? DepthLen : length;
   assign accept      = (state_q == StRun) && in_valid;
   assign last        = accept && ((idx_q + IdxOne) == len_q);

   assign busy      = (state_q != StIdle);
   assign in_ready  = (state_q == StRun);
   assign out_valid = (state_q == StDone);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      drain_d   = drain_q;
      clr       = 1'b0;
      load      = 1'b0;
      load_zero = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               clr   = 1'b1;
               idx_d = '0;
               len_d = len_clamped;
               if (length == '0) begin
                  load      = 1'b1;
                  load_zero = 1'b1;
                  state_d   = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (accept) begin
               idx_d = idx_q + IdxOne;
               if (last) begin
                  drain_d = 1'b0;
                  state_d = StDrain;
               end
            end
         end
         // Cycle 1 lets the final product accumulate; cycle 2 captures the result.
         StDrain: begin
            drain_d = 1'b1;
            if (drain_q) begin
               load    = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         drain_q <= 1'b0;
         x_q     <= '0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         v_q     <= accept;
         if (accept) begin
            x_q <= in_data;
         end
      end
   end

   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
      logic lane_wr;
      assign lane_wr = wr_en && !busy && (wr_unit == U_SEL_BITS'(k));

      neuron_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .FRAC_BITS   (FRAC_BITS),
         .BRAM_DEPTH  (BRAM_DEPTH),
         .ACC_WIDTH   (ACC_WIDTH),
         .W_ADDR_BITS (W_ADDR_BITS)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (lane_wr),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .rd_en     (accept),
         .rd_addr   (idx_q[W_ADDR_BITS-1:0]),
         .x         (x_q),
         .acc_en    (v_q),
         .clr       (clr),
         .load      (load),
         .load_zero (load_zero),
         .result    (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .ovf       (overflow[k])
      );
   end

endmodule
